mic_window_scheduler: RTL and testbench

//  Sequences microphone level measurement on the 20 kHz sample clock, between the 12-bit ADC sample stream and the LED/7-seg volume display.

---
 rtl/mic_sched_pkg.sv | 39 +++
 rtl/window_peak_tracker.sv | 39 +++
 rtl/mic_window_scheduler.sv | 134 +++++++++++++
 tb/tb_mic_window_scheduler.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mic_sched_pkg.sv
// Shared types, widths and arithmetic helpers for the microphone window scheduler.
package mic_sched_pkg;

    localparam int ADC_W     = 12;
    localparam int VOL_W     = 4;
    localparam int VOL_SHIFT = 7;
    localparam int VOL_MAX   = 15;

    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        CALIB  = 2'd1,
        RUN    = 2'd2,
        PAUSE  = 2'd3
    } state_t;

    // Floor-subtracted amplitude; a clipped or sub-floor peak reads as silence.
    function automatic logic [ADC_W-1:0] calc_amp(
        input logic [ADC_W-1:0] win_peak,
        input logic [ADC_W-1:0] floor_val,
        input logic [ADC_W-1:0] clip_code
    );
        if ((win_peak == clip_code) || (win_peak <= floor_val)) begin
            return {ADC_W{1'b0}};
        end else begin
            return win_peak - floor_val;
        end
    endfunction

    function automatic logic [VOL_W-1:0] calc_volume(input logic [ADC_W-1:0] amp);
        logic [ADC_W-1:0] shifted;
        shifted = amp >> VOL_SHIFT;
        if (shifted > ADC_W'(VOL_MAX)) begin
            return VOL_W'(VOL_MAX);
        end else begin
            return shifted[VOL_W-1:0];
        end
    endfunction

endpackage

// File: rtl/window_peak_tracker.sv
// Counts samples into fixed-length windows and tracks the running peak of each window.
module window_peak_tracker
    import mic_sched_pkg::*;
#(
    parameter int unsigned WINDOW_LEN = 10000
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [ADC_W-1:0] sample,
    output logic [ADC_W-1:0] win_peak,
    output logic             window_end
);

    localparam int CNT_W = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW_LEN - 1);

    logic [CNT_W-1:0] count_r;
    logic [ADC_W-1:0] peak_r;

    // win_peak includes the current sample, so the window-end sample is never lost.
    assign win_peak   = (sample > peak_r) ? sample : peak_r;
    assign window_end = (count_r == LAST_CNT);

    // Sample counter and running peak, restarted at each window end or on clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
            peak_r  <= {ADC_W{1'b0}};
        end else if (clear || window_end) begin
            count_r <= {CNT_W{1'b0}};
            peak_r  <= {ADC_W{1'b0}};
        end else begin
            count_r <= count_r + CNT_W'(1);
            peak_r  <= win_peak;
        end
    end

endmodule

// File: rtl/mic_window_scheduler.sv
// Settle / calibrate / measure sequencer turning windowed ADC peaks into a floor-relative
// amplitude and a 0-15 volume level.
module mic_window_scheduler
    import mic_sched_pkg::*;
#(
    parameter int unsigned WINDOW_LEN    = 10000,
    parameter int unsigned CALIB_WINDOWS = 4,
    parameter int unsigned DEFAULT_FLOOR = 2048,
    parameter int unsigned CLIP_CODE     = 4095
)(
    input  logic             Clk_20khz,
    input  logic             Rst,
    input  logic [ADC_W-1:0] mic_in,
    input  logic             enable,
    input  logic             recal,
    output logic             window_done,
    output logic             level_valid,
    output logic [ADC_W-1:0] peak_amplitude,
    output logic [VOL_W-1:0] volume_level,
    output logic [ADC_W-1:0] noise_floor,
    output logic             calib_done,
    output logic             calib_err,
    output logic             clip
);

    localparam int IDX_W = (CALIB_WINDOWS > 1) ? $clog2(CALIB_WINDOWS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(CALIB_WINDOWS - 1);
    localparam logic [ADC_W-1:0] DEF_FLOOR = ADC_W'(DEFAULT_FLOOR);
    localparam logic [ADC_W-1:0] CLIP_VAL  = ADC_W'(CLIP_CODE);

    state_t           state_r;
    logic [ADC_W-1:0] cal_max_r;
    logic [IDX_W-1:0] win_idx_r;
    logic [ADC_W-1:0] noise_floor_r;
    logic             calib_done_r;
    logic             calib_err_r;
    logic [ADC_W-1:0] peak_amp_r;
    logic [VOL_W-1:0] volume_r;
    logic             level_valid_r;
    logic             clip_r;

    logic [ADC_W-1:0] win_peak_s;
    logic             window_end_s;
    logic             recal_s;
    logic             clear_s;
    logic [ADC_W-1:0] cal_max_next_s;
    logic [ADC_W-1:0] amp_s;
    logic             run_end_s;

    // SETTLE must complete before recal can act; a recal there is dropped.
    assign recal_s        = recal && (state_r != SETTLE);
    assign clear_s        = recal_s || (state_r == PAUSE);
    assign cal_max_next_s = (win_peak_s > cal_max_r) ? win_peak_s : cal_max_r;
    assign amp_s          = calc_amp(win_peak_s, noise_floor_r, CLIP_VAL);
    assign run_end_s      = (state_r == RUN) && window_end_s && !recal_s;

    window_peak_tracker #(
        .WINDOW_LEN (WINDOW_LEN)
    ) u_tracker (
        .clk        (Clk_20khz),
        .rst        (Rst),
        .clear      (clear_s),
        .sample     (mic_in),
        .win_peak   (win_peak_s),
        .window_end (window_end_s)
    );

    // Sequencer state and noise-floor calibration.
    always_ff @(posedge Clk_20khz or posedge Rst) begin
        if (Rst) begin
            state_r       <= SETTLE;
            cal_max_r     <= {ADC_W{1'b0}};
            win_idx_r     <= {IDX_W{1'b0}};
            noise_floor_r <= DEF_FLOOR;
            calib_done_r  <= 1'b0;
            calib_err_r   <= 1'b0;
        end else if (recal_s) begin
            state_r      <= CALIB;
            cal_max_r    <= {ADC_W{1'b0}};
            win_idx_r    <= {IDX_W{1'b0}};
            calib_done_r <= 1'b0;
            calib_err_r  <= 1'b0;
        end else begin
            case (state_r)
                SETTLE: if (window_end_s) state_r <= CALIB;
                CALIB: begin
                    if (window_end_s) begin
                        if (win_idx_r == LAST_IDX) begin
                            noise_floor_r <= (cal_max_next_s == CLIP_VAL) ? DEF_FLOOR : cal_max_next_s;
                            calib_err_r   <= (cal_max_next_s == CLIP_VAL);
                            calib_done_r  <= 1'b1;
                            cal_max_r     <= {ADC_W{1'b0}};
                            win_idx_r     <= {IDX_W{1'b0}};
                            state_r       <= RUN;
                        end else begin
                            cal_max_r <= cal_max_next_s;
                            win_idx_r <= win_idx_r + IDX_W'(1);
                        end
                    end
                end
                RUN:     if (!enable) state_r <= PAUSE;
                PAUSE:   if (enable)  state_r <= RUN;
                default: state_r <= SETTLE;
            endcase
        end
    end

    // Level outputs, registered one cycle after a RUN window ends.
    always_ff @(posedge Clk_20khz or posedge Rst) begin
        if (Rst) begin
            peak_amp_r    <= {ADC_W{1'b0}};
            volume_r      <= {VOL_W{1'b0}};
            level_valid_r <= 1'b0;
            clip_r        <= 1'b0;
        end else begin
            level_valid_r <= run_end_s;
            clip_r        <= run_end_s && (win_peak_s == CLIP_VAL);
            if (run_end_s) begin
                peak_amp_r <= amp_s;
                volume_r   <= calc_volume(amp_s);
            end
        end
    end

    assign window_done    = window_end_s && (state_r != PAUSE);
    assign level_valid    = level_valid_r;
    assign peak_amplitude = peak_amp_r;
    assign volume_level   = volume_r;
    assign noise_floor    = noise_floor_r;
    assign calib_done     = calib_done_r;
    assign calib_err      = calib_err_r;
    assign clip           = clip_r;

endmodule

// File: tb/tb_mic_window_scheduler.sv
// Scenario-driven bench for mic_window_scheduler with 16-sample windows and 2 calibration windows.
module tb_mic_window_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] mic_in = 12'd0;
    logic        enable = 1'b1;
    logic        recal = 1'b0;
    logic        window_done, level_valid, calib_done, calib_err, clip;
    logic [11:0] peak_amplitude, noise_floor;
    logic [3:0]  volume_level;

    typedef struct packed {
        logic [11:0] amp;
        logic [3:0]  vol;
        logic        clp;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int compared = 0;
    int mismatched = 0;
    int done_seen, done_at, lv_seen;
    logic [11:0] last_amp = 12'd0;
    logic [3:0]  last_vol = 4'd0;

    mic_window_scheduler #(
        .WINDOW_LEN    (16),
        .CALIB_WINDOWS (2),
        .DEFAULT_FLOOR (2048),
        .CLIP_CODE     (4095)
    ) dut (
        .Clk_20khz      (clk),
        .Rst            (rst),
        .mic_in         (mic_in),
        .enable         (enable),
        .recal          (recal),
        .window_done    (window_done),
        .level_valid    (level_valid),
        .peak_amplitude (peak_amplitude),
        .volume_level   (volume_level),
        .noise_floor    (noise_floor),
        .calib_done     (calib_done),
        .calib_err      (calib_err),
        .clip           (clip)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within bound");
        $fatal(1, "timeout");
    end

    // Drives n samples (base, then last on the final one) and records observed pulses.
    task automatic drive(input logic [11:0] base, input logic [11:0] last, input int n);
        done_seen = 0; done_at = -1; lv_seen = 0;
        for (int i = 0; i < n; i++) begin
            mic_in = (i == n - 1) ? last : base;
            if (window_done) begin done_seen++; done_at = i; end
            @(posedge clk); @(negedge clk);
            if (level_valid) lv_seen++;
        end
    endtask

    task automatic pulse_recal();
        recal = 1'b1; mic_in = 12'd500;
        @(posedge clk); @(negedge clk);
        recal = 1'b0;
    endtask

    task automatic test_reset();
        logic [34:0] obs, exp_v;
        @(negedge clk); @(negedge clk);
        obs   = {peak_amplitude, volume_level, noise_floor, calib_done, calib_err, level_valid, clip, window_done};
        exp_v = {12'd0, 4'd0, 12'd2048, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        compared++;
        if (obs !== exp_v) begin mismatched++; $display("FAIL reset_values: got %h expected %h", obs, exp_v); end
        rst = 1'b0;
    endtask

    task automatic test_calibration();
        for (int w = 0; w < 3; w++) begin
            drive(12'd1000, 12'd1000, 16);
            compared++;
            if (done_seen !== 1 || done_at !== 15 || lv_seen !== 0) begin
                mismatched++;
                $display("FAIL calib_window%0d: done_seen=%0d done_at=%0d lv=%0d expected 1/15/0", w, done_seen, done_at, lv_seen);
            end
        end
        compared++;
        if ({noise_floor, calib_done, calib_err} !== {12'd1000, 1'b1, 1'b0}) begin
            mismatched++;
            $display("FAIL calib_floor: floor=%0d done=%b err=%b expected 1000/1/0", noise_floor, calib_done, calib_err);
        end
    endtask

    task automatic test_levels();
        logic [11:0] lasts [6] = '{12'd3000, 12'd1200, 12'd900, 12'd4095, 12'd1000, 12'd2047};
        exp_t        exps  [6] = '{{12'd2000, 4'd15, 1'b0}, {12'd200, 4'd1, 1'b0}, {12'd0, 4'd0, 1'b0},
                                   {12'd0, 4'd0, 1'b1}, {12'd0, 4'd0, 1'b0}, {12'd1047, 4'd8, 1'b0}};
        for (int k = 0; k < 6; k++) begin
            sb.push_back(exps[k]);
            drive(12'd500, lasts[k], 16);
            e = sb.pop_front();
            last_amp = e.amp; last_vol = e.vol;
            compared++;
            if (lv_seen !== 1 || done_at !== 15 || {peak_amplitude, volume_level, clip} !== e) begin
                mismatched++;
                $display("FAIL level_%0d: lv=%0d done_at=%0d amp=%0d vol=%0d clip=%b expected lv=1 done_at=15 amp=%0d vol=%0d clip=%b",
                         lasts[k], lv_seen, done_at, peak_amplitude, volume_level, clip, e.amp, e.vol, e.clp);
            end
        end
    endtask

    task automatic test_calib_clip();
        pulse_recal();
        compared++;
        if ({calib_done, calib_err, noise_floor, peak_amplitude} !== {1'b0, 1'b0, 12'd1000, last_amp}) begin
            mismatched++;
            $display("FAIL recal_start: done=%b err=%b floor=%0d amp=%0d expected 0/0/1000/%0d", calib_done, calib_err, noise_floor, peak_amplitude, last_amp);
        end
        drive(12'd1000, 12'd4095, 16);
        drive(12'd1000, 12'd1000, 16);
        compared++;
        if ({noise_floor, calib_done, calib_err} !== {12'd2048, 1'b1, 1'b1}) begin
            mismatched++;
            $display("FAIL calib_clip: floor=%0d done=%b err=%b expected 2048/1/1", noise_floor, calib_done, calib_err);
        end
        pulse_recal();
        compared++;
        if ({calib_err, noise_floor} !== {1'b0, 12'd2048}) begin
            mismatched++;
            $display("FAIL err_clear: err=%b floor=%0d expected 0/2048", calib_err, noise_floor);
        end
        enable = 1'b0;
        for (int w = 0; w < 2; w++) begin
            drive(12'd1000, 12'd1000, 16);
            compared++;
            if (done_seen !== 1 || done_at !== 15) begin
                mismatched++;
                $display("FAIL calib_enable_low%0d: done_seen=%0d done_at=%0d expected 1/15", w, done_seen, done_at);
            end
        end
        enable = 1'b1;
        compared++;
        if ({noise_floor, calib_done, calib_err} !== {12'd1000, 1'b1, 1'b0}) begin
            mismatched++;
            $display("FAIL recalib_floor: floor=%0d done=%b err=%b expected 1000/1/0", noise_floor, calib_done, calib_err);
        end
    endtask

    task automatic test_pause();
        drive(12'd500, 12'd500, 5);
        enable = 1'b0;
        drive(12'd4000, 12'd4000, 20);
        compared++;
        if (done_seen !== 0 || lv_seen !== 0 || {peak_amplitude, volume_level, noise_floor} !== {last_amp, last_vol, 12'd1000}) begin
            mismatched++;
            $display("FAIL pause_hold: done=%0d lv=%0d amp=%0d vol=%0d floor=%0d expected 0/0/%0d/%0d/1000",
                     done_seen, lv_seen, peak_amplitude, volume_level, noise_floor, last_amp, last_vol);
        end
        enable = 1'b1; mic_in = 12'd4000;
        @(posedge clk); @(negedge clk);
        sb.push_back('{12'd300, 4'd2, 1'b0});
        drive(12'd1000, 12'd1300, 16);
        e = sb.pop_front();
        last_amp = e.amp; last_vol = e.vol;
        compared++;
        if (done_seen !== 1 || done_at !== 15 || lv_seen !== 1 || {peak_amplitude, volume_level, clip} !== e) begin
            mismatched++;
            $display("FAIL resume_window: done=%0d at=%0d lv=%0d amp=%0d vol=%0d expected 1/15/1/%0d/%0d",
                     done_seen, done_at, lv_seen, peak_amplitude, volume_level, e.amp, e.vol);
        end
        // Window end on the same edge enable falls is still reported.
        drive(12'd500, 12'd500, 15);
        sb.push_back('{12'd500, 4'd3, 1'b0});
        enable = 1'b0; mic_in = 12'd1500;
        @(posedge clk); @(negedge clk);
        e = sb.pop_front();
        last_amp = e.amp; last_vol = e.vol;
        compared++;
        if (level_valid !== 1'b1 || {peak_amplitude, volume_level, clip} !== e) begin
            mismatched++;
            $display("FAIL end_on_disable: lv=%b amp=%0d vol=%0d expected 1/%0d/%0d", level_valid, peak_amplitude, volume_level, e.amp, e.vol);
        end
        drive(12'd500, 12'd500, 4);
        compared++;
        if (done_seen !== 0 || lv_seen !== 0 || {peak_amplitude, volume_level} !== {last_amp, last_vol}) begin
            mismatched++;
            $display("FAIL pause_after_end: done=%0d lv=%0d amp=%0d vol=%0d expected 0/0/%0d/%0d", done_seen, lv_seen, peak_amplitude, volume_level, last_amp, last_vol);
        end
        enable = 1'b1; mic_in = 12'd500;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_recal_window_end();
        drive(12'd500, 12'd500, 15);
        recal = 1'b1; mic_in = 12'd3000;
        @(posedge clk); @(negedge clk);
        recal = 1'b0;
        compared++;
        if (level_valid !== 1'b0 || calib_done !== 1'b0 || peak_amplitude !== last_amp) begin
            mismatched++;
            $display("FAIL recal_vs_end: lv=%b done=%b amp=%0d expected 0/0/%0d", level_valid, calib_done, peak_amplitude, last_amp);
        end
        drive(12'd1500, 12'd1500, 16);
        drive(12'd1500, 12'd1500, 16);
        compared++;
        if ({noise_floor, calib_done} !== {12'd1500, 1'b1}) begin
            mismatched++;
            $display("FAIL recal_new_floor: floor=%0d done=%b expected 1500/1", noise_floor, calib_done);
        end
        sb.push_back('{12'd500, 4'd3, 1'b0});
        drive(12'd500, 12'd2000, 16);
        e = sb.pop_front();
        compared++;
        if (lv_seen !== 1 || {peak_amplitude, volume_level, clip} !== e) begin
            mismatched++;
            $display("FAIL new_floor_level: lv=%0d amp=%0d vol=%0d expected 1/%0d/%0d", lv_seen, peak_amplitude, volume_level, e.amp, e.vol);
        end
    endtask

    task automatic test_reset_mid_calib();
        logic [34:0] obs, exp_v;
        pulse_recal();
        drive(12'd700, 12'd700, 5);
        rst = 1'b1;
        #1;
        obs   = {peak_amplitude, volume_level, noise_floor, calib_done, calib_err, level_valid, clip, window_done};
        exp_v = {12'd0, 4'd0, 12'd2048, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        compared++;
        if (obs !== exp_v) begin mismatched++; $display("FAIL reset_mid_calib: got %h expected %h", obs, exp_v); end
        @(negedge clk);
        rst = 1'b0;
        drive(12'd1000, 12'd1000, 16);
        compared++;
        if (done_seen !== 1 || done_at !== 15 || calib_done !== 1'b0 || noise_floor !== 12'd2048) begin
            mismatched++;
            $display("FAIL settle_after_reset: done=%0d at=%0d cdone=%b floor=%0d expected 1/15/0/2048", done_seen, done_at, calib_done, noise_floor);
        end
    endtask

    initial begin
        test_reset();
        test_calibration();
        test_levels();
        test_calib_clip();
        test_pause();
        test_recal_window_end();
        test_reset_mid_calib();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
